// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- RV32I instruction fetch stage.
//
// Holds the program counter and issues word fetches to instruction memory.
// Each granted request gets a slot in a small circular reservation queue.
// Returned words land in those slots in request order. The head slot is
// presented to decode. A redirect from execute squashes everything in flight.
//
// Ports
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   o_imem_req       fetch request (combinational: credit, redirect, stall)
//   o_imem_addr      word-aligned fetch address (the PC register)
//   i_imem_gnt       memory accepted the request this cycle
//   i_imem_rvalid    response word valid; in request order, >=1 cycle later
//   i_imem_rdata     response instruction word
//   i_redirect       taken branch/jump from execute
//   i_redirect_pc    new fetch address; low two bits are dropped
//   i_id_stall       decode cannot accept this cycle
//   o_id_valid       o_id_instr/o_id_pc/o_id_pc_plus4 valid
//   o_id_instr       instruction at queue head
//   o_id_pc          PC of o_id_instr
//   o_id_pc_plus4    o_id_pc + 4, wrapping at 2^32
//   o_dbg_drop_cnt   responses still owed for squashed requests
//
// Handshakes:
//   - imem: a request transfers on a cycle where o_imem_req & i_imem_gnt.
//     o_imem_addr is held while o_imem_req stays high and no grant arrives.
//   - decode: a word transfers on a cycle where o_id_valid & ~i_id_stall.
//     While o_id_valid & i_id_stall, all o_id_* outputs hold.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  output logic                       o_imem_req,
  output logic [31:0]                o_imem_addr,
  input  logic                       i_imem_gnt,
  input  logic                       i_imem_rvalid,
  input  logic [31:0]                i_imem_rdata,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_pc,
  input  logic                       i_id_stall,
  output logic                       o_id_valid,
  output logic [31:0]                o_id_instr,
  output logic [31:0]                o_id_pc,
  output logic [31:0]                o_id_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] o_dbg_drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]      r_pc;
  logic [31:0]      r_slot_pc    [DEPTH];
  logic [31:0]      r_slot_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW-1:0]    r_fill_ptr;  // oldest allocated, unfilled slot
  logic [CW-1:0]    r_alloc;     // allocated slots
  logic [CW-1:0]    r_pend;      // allocated slots still waiting for a word
  logic [CW-1:0]    r_drop;      // responses owed to squashed requests

  logic             w_head_ok;
  logic             w_pop;
  logic             w_grant;
  logic             w_rsp_fill;
  logic             w_rsp_drop;
  logic [CW:0]      w_credit;
  logic             w_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign w_unused = ^i_redirect_pc[1:0];

  assign w_head_ok  = (r_alloc != '0) & r_filled[r_head];
  assign o_id_valid = i_rst_n & w_head_ok & ~i_redirect;
  assign w_pop      = o_id_valid & ~i_id_stall;

  // Every issued request must have somewhere to land: a free slot, or a
  // slot freed by this cycle's pop. Squashed-but-owed responses also hold
  // credit until they drain, so a returning word never overflows the queue.
  assign w_credit   = (CW+1)'(r_alloc) + (CW+1)'(r_drop) - (CW+1)'(w_pop);
  assign o_imem_req = i_rst_n & ~i_redirect & (w_credit < (CW+1)'(DEPTH));
  assign o_imem_addr = r_pc;
  assign w_grant    = o_imem_req & i_imem_gnt;

  assign w_rsp_drop = i_imem_rvalid & (r_drop != '0);
  assign w_rsp_fill = i_imem_rvalid & (r_drop == '0);

  assign o_id_instr    = i_rst_n ? r_slot_instr[r_head] : 32'd0;
  assign o_id_pc       = i_rst_n ? r_slot_pc[r_head] : 32'd0;
  assign o_id_pc_plus4 = i_rst_n ? (r_slot_pc[r_head] + 32'd4) : 32'd0;
  assign o_dbg_drop_cnt = r_drop;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_fill_ptr <= '0;
      r_alloc    <= '0;
      r_pend     <= '0;
      r_drop     <= '0;
      r_filled   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_slot_pc[i]    <= '0;
        r_slot_instr[i] <= '0;
      end
    end else if (i_redirect) begin
      // Redirect overrides pop, grant and fill. Unfilled slots turn into
      // owed responses; a word arriving this very cycle is already gone.
      r_pc       <= {i_redirect_pc[31:2], 2'b00};
      r_head     <= r_tail;
      r_fill_ptr <= r_tail;
      r_alloc    <= '0;
      r_pend     <= '0;
      r_filled   <= '0;
      r_drop     <= r_drop + r_pend - CW'(i_imem_rvalid);
    end else begin
      if (w_pop) begin
        r_filled[r_head] <= 1'b0;
        r_head           <= ptr_inc(r_head);
      end
      if (w_grant) begin
        r_slot_pc[r_tail] <= r_pc;
        r_filled[r_tail]  <= 1'b0;
        r_tail            <= ptr_inc(r_tail);
        r_pc              <= r_pc + 32'd4;
      end
      // The fill slot is never the tail (not yet allocated) nor a popped
      // head (already filled), so these writes never collide.
      if (w_rsp_fill) begin
        r_slot_instr[r_fill_ptr] <= i_imem_rdata;
        r_filled[r_fill_ptr]     <= 1'b1;
        r_fill_ptr               <= ptr_inc(r_fill_ptr);
      end
      if (w_rsp_drop) r_drop <= r_drop - CW'(1);
      r_alloc <= r_alloc + CW'(w_grant) - CW'(w_pop);
      r_pend  <= r_pend + CW'(w_grant) - CW'(w_rsp_fill);
    end
  end

endmodule
